// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and IF/ID.
// Issues sequential word fetches over a req/ack interface and buffers up to
// DEPTH {instruction, PC+4} entries. The oldest entry is presented to IF/ID.
// A redirect flushes the queue and restarts fetching from redirect_pc. If a
// request is still outstanding at that point, the stale ack is drained first.
// Optional feature: define FETCHQ_STATS_EN to add the stat_drops/stat_empty
// saturating counters.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_async_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] npc_out
`ifdef FETCHQ_STATS_EN
  ,
  output logic [15:0] stat_drops,
  output logic [15:0] stat_empty
`endif
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  // IDLE: queue full, no request. REQ: live fetch at fetch_pc.
  // DROP: draining a request that a redirect made stale.
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   stale_addr, stale_addr_next;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic          enq, deq;

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_npc  [DEPTH];

  // Handshake decode and the occupancy after this edge.
  always_comb begin
    enq = (state == REQ) && imem_ack && !redirect;
    deq = inst_valid && deq_ready && !redirect;
    if (redirect) count_next = '0;
    else          count_next = count + CW'(enq) - CW'(deq);
  end

  // Next-state and fetch-address logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (which would infer a latch).
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    stale_addr_next = stale_addr;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          state_next    = REQ;
          fetch_pc_next = redirect_pc;
        end else if (count_next < DEPTH_C) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
          if (!imem_ack) begin
            // Memory still owes us this word; keep presenting its address.
            state_next      = DROP;
            stale_addr_next = fetch_pc;
          end
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = (count_next < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_next = redirect_pc;
        if (imem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state, fetch PC and queue pointers.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      stale_addr <= RESET_PC;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      stale_addr <= stale_addr_next;
      count      <= count_next;
      if (redirect) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (deq) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; empty-queue outputs are forced to zero instead.
    if (enq) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_npc[wr_ptr]  <= fetch_pc + 32'd4;
    end
  end

  assign imem_req   = (state != IDLE);
  assign imem_addr  = (state == DROP) ? stale_addr : fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? mem_inst[rd_ptr] : '0;
  assign npc_out    = inst_valid ? mem_npc[rd_ptr]  : '0;

`ifdef FETCHQ_STATS_EN
  logic ack_drop;
  assign ack_drop = imem_ack && (((state == REQ) && redirect) || (state == DROP));

  // Saturating counters of discarded acks and starved consumer cycles.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      stat_drops <= '0;
      stat_empty <= '0;
    end else begin
      if (ack_drop && (stat_drops != 16'hFFFF))
        stat_drops <= stat_drops + 16'd1;
      if (!inst_valid && deq_ready && (stat_empty != 16'hFFFF))
        stat_empty <= stat_empty + 16'd1;
    end
  end
`endif

endmodule
